// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, bit-period helper and the 2-of-3 vote.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } uart_state_e;

  // Same integer-divide bit period that uart_tx uses, so both ends agree on timing.
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous bit; RST_VAL sets the reset/idle level.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8-N-1 UART receiver with mid-bit sampling, framing-error flag and break hold-off.
// Build option UART_RX_MAJORITY_EN: 2-of-3 vote around each sample point (needs CLKS_PER_BIT >= 6).
//
// state   | meaning
// S_IDLE  | line idle, waiting for rx_s low
// S_START | half-bit wait, re-check start bit
// S_DATA  | sampling 8 data bits, LSB first
// S_STOP  | sampling stop bit
// S_BREAK | stop bit was low, wait for line to go high
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD_RATE = 115200,
  parameter int          CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err
);

  localparam int unsigned CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam logic [CNT_W-1:0] LIM_BIT  = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] LIM_HALF = CNT_W'(CPB / 2 - 1);

  logic rx_s;

  uart_sync2 #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  logic [CNT_W-1:0] limit;
  logic             at_limit;
  logic             samp_now;
  logic             samp_bit;

`ifdef UART_RX_MAJORITY_EN
  logic s0_q, s0_d;
  logic s1_q, s1_d;
  logic pend_q, pend_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      s0_q    <= 1'b1;
      s1_q    <= 1'b1;
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_MAJORITY_EN
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      pend_q  <= pend_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    limit    = (state_q == S_START) ? LIM_HALF : LIM_BIT;
    at_limit = (cnt_q == limit);

`ifdef UART_RX_MAJORITY_EN
    // Votes on limit-1, limit and limit+1; the decision cycle restarts the count at 1.
    s0_d     = s0_q;
    s1_d     = s1_q;
    pend_d   = 1'b0;
    samp_now = pend_q;
    samp_bit = maj3(s0_q, s1_q, rx_s);
    if (cnt_q == limit - CNT_W'(1)) s0_d = rx_s;
    if (pend_q) begin
      cnt_d = CNT_W'(1);
    end else if (at_limit) begin
      s1_d   = rx_s;
      pend_d = 1'b1;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
`else
    samp_now = at_limit;
    samp_bit = rx_s;
    cnt_d    = at_limit ? '0 : cnt_q + CNT_W'(1);
`endif

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
`ifdef UART_RX_MAJORITY_EN
        pend_d = 1'b0;
`endif
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (samp_now) begin
          if (!samp_bit) begin
            state_d = S_DATA;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
      end
      S_DATA: begin
        if (samp_now) begin
          shift_d[idx_q] = samp_bit;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (samp_now) begin
          cnt_d = '0;
          if (samp_bit) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
`ifdef UART_RX_MAJORITY_EN
        pend_d = 1'b0;
`endif
        if (rx_s) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign rx_busy   = (state_q != S_IDLE);

endmodule
